// File: rtl/blake2s_host_tx.sv
// Host-side driver for the BLAKE2s pin link: sends config bytes and zero-padded 64-byte blocks,
// then captures the digest bytes returned on hash/hash_finished.
module blake2s_host_tx #(
  parameter int unsigned BLOCK_GAP = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic [63:0] ll_i,
  input  logic        msg_v_i,
  input  logic [7:0]  msg_i,
  output logic        msg_ready_o,
  output logic        valid_o,
  output logic [1:0]  cmd_o,
  output logic [7:0]  data_o,
  input  logic        hash_finished_i,
  input  logic [7:0]  hash_i,
  output logic        hash_v_o,
  output logic [7:0]  hash_o,
  output logic [4:0]  hash_idx_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    StIdle, StConf, StKey, StData, StPad, StGap, StWaitHash, StRead
  } state_e;

  localparam logic [1:0] CmdConf  = 2'd0;
  localparam logic [1:0] CmdData  = 2'd1;
  localparam logic [1:0] CmdAbort = 2'd3;

  state_e      state_q;
  logic [5:0]  kk_q;       // doubles as remaining key bytes once CONF is done
  logic [5:0]  nn_q;
  logic [63:0] rem_q;      // remaining message bytes; holds ll during CONF
  logic [3:0]  conf_idx_q;
  logic [5:0]  blk_cnt_q;
  logic [31:0] gap_cnt_q;
  logic [5:0]  rd_cnt_q;
  logic        valid_q;
  logic [1:0]  cmd_q;
  logic [7:0]  data_q;
  logic        hash_v_q;
  logic [7:0]  hash_q;
  logic [4:0]  hash_idx_q;
  logic        done_q;

  logic [3:0] conf_sel;
  logic [7:0] conf_byte;
  logic       hs;
  logic       blk_last;

  always_comb begin
    conf_sel  = conf_idx_q - 4'd2;
    conf_byte = 8'h00;
    case (conf_idx_q)
      4'd0:    conf_byte = {2'b00, kk_q};
      4'd1:    conf_byte = {2'b00, nn_q};
      default: conf_byte = rem_q[{conf_sel[2:0], 3'b000} +: 8];
    endcase
  end

  assign msg_ready_o = ((state_q == StKey) && (kk_q != 6'd0)) ||
                       ((state_q == StData) && (rem_q != 64'd0));
  assign hs          = msg_ready_o & msg_v_i;
  assign blk_last    = (blk_cnt_q == 6'd63);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      kk_q       <= '0;
      nn_q       <= '0;
      rem_q      <= '0;
      conf_idx_q <= '0;
      blk_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      valid_q    <= 1'b0;
      cmd_q      <= CmdConf;
      data_q     <= '0;
      hash_v_q   <= 1'b0;
      hash_q     <= '0;
      hash_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      hash_v_q <= 1'b0;
      done_q   <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        state_q <= StIdle;
        valid_q <= 1'b1;
        cmd_q   <= CmdAbort;
        data_q  <= 8'h00;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              kk_q       <= kk_i;
              nn_q       <= nn_i;
              rem_q      <= ll_i;
              conf_idx_q <= 4'd1;
              blk_cnt_q  <= '0;
              valid_q    <= 1'b1;
              cmd_q      <= CmdConf;
              data_q     <= {2'b00, kk_i};
              state_q    <= StConf;
            end
          end
          StConf: begin
            valid_q    <= 1'b1;
            cmd_q      <= CmdConf;
            data_q     <= conf_byte;
            conf_idx_q <= conf_idx_q + 4'd1;
            if (conf_idx_q == 4'd9) begin
              // An empty job with no key goes straight to an all-zero block.
              if (kk_q != 6'd0)          state_q <= StKey;
              else if (rem_q == 64'd0)   state_q <= StPad;
              else                       state_q <= StData;
            end
          end
          StKey: begin
            if (hs) begin
              valid_q   <= 1'b1;
              cmd_q     <= CmdData;
              data_q    <= msg_i;
              blk_cnt_q <= blk_cnt_q + 6'd1;
              kk_q      <= kk_q - 6'd1;
              if (kk_q == 6'd1) state_q <= StPad;
            end
          end
          StData: begin
            if (hs) begin
              valid_q   <= 1'b1;
              cmd_q     <= CmdData;
              data_q    <= msg_i;
              blk_cnt_q <= blk_cnt_q + 6'd1;
              rem_q     <= rem_q - 64'd1;
              if (blk_last) begin
                gap_cnt_q <= '0;
                state_q   <= (rem_q == 64'd1) ? StWaitHash : StGap;
              end else if (rem_q == 64'd1) begin
                state_q <= StPad;
              end
            end else if (rem_q == 64'd0) begin
              state_q <= StPad;
            end
          end
          StPad: begin
            valid_q   <= 1'b1;
            cmd_q     <= CmdData;
            data_q    <= 8'h00;
            blk_cnt_q <= blk_cnt_q + 6'd1;
            if (blk_last) begin
              gap_cnt_q <= '0;
              state_q   <= (rem_q == 64'd0) ? StWaitHash : StGap;
            end
          end
          StGap: begin
            if (gap_cnt_q + 32'd1 >= BLOCK_GAP) state_q <= StData;
            else                                gap_cnt_q <= gap_cnt_q + 32'd1;
          end
          StWaitHash: begin
            if (hash_finished_i) begin
              hash_v_q   <= 1'b1;
              hash_q     <= hash_i;
              hash_idx_q <= 5'd0;
              rd_cnt_q   <= 6'd1;
              state_q    <= StRead;
            end
          end
          StRead: begin
            // A short hash_finished run ends the job early, still with done.
            if (hash_finished_i && (rd_cnt_q != nn_q)) begin
              hash_v_q   <= 1'b1;
              hash_q     <= hash_i;
              hash_idx_q <= rd_cnt_q[4:0];
              rd_cnt_q   <= rd_cnt_q + 6'd1;
            end else begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        endcase
      end
    end
  end

  assign valid_o    = valid_q;
  assign cmd_o      = cmd_q;
  assign data_o     = data_q;
  assign hash_v_o   = hash_v_q;
  assign hash_o     = hash_q;
  assign hash_idx_o = hash_idx_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;

endmodule
